data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Responder side of the M-stage data memory interface: accepts the pipeline's read/write request (memRead, memWrite, address, dataWrite, byte/word select), services it from byte-organised storage after a configurable number of wait states, and returns read data with a one-cycle valid pulse. While an access is in flight it drives memStall, which the hazard logic uses to hold PC, IF/ID, ID/EX and EX/M. It replaces the fixed single-cycle data memory behind the M stage so the core tolerates slow memory.

## Interface
- DEPTH_BYTES, 512: storage size in bytes; power of two, at least 2.
- WAIT_STATES, 2: extra cycles between request acceptance and completion; 0 to 15.
- clk  input  1: system clock; all state updates on rising edge.
- reset_n  input  1: synchronous, active-low reset, sampled on rising edge of clk.
- memRead  input  1: read request (EX/M bit 52).
- memWrite  input  1: write request (EX/M bit 53).
- byteAccess  input  1: 1 = byte access; 0 = 16-bit word access (EX/M zeroExtendFlag).
- address  input  16: byte address (EX/M ALU result).
- dataWrite  input  16: store data.
- dataRead  output  16: load data; held until the next completed read.
- memValid  output  1: one-cycle pulse marking access completion.
- memStall  output  1: pipeline hold request.
- addrError  output  1: one-cycle pulse with memValid on a misaligned word access.

## Operation
- Storage: DEPTH_BYTES bytes. Index = address mod DEPTH_BYTES; higher address bits are ignored, so accesses wrap.
- Word layout is big-endian. At even address A, bits [15:8] are byte A and bits [7:0] are byte A+1.
- Word read returns {mem[A], mem[A+1]}. Word write stores dataWrite[15:8] to A and dataWrite[7:0] to A+1.
- Byte read returns {8'h00, mem[A]}, zero-extended inside the block. Byte write stores dataWrite[7:0] to A only.
- If memRead and memWrite are both high, the access is a write. dataRead is unchanged.
- FSM states: IDLE, WAIT, DONE.
  - IDLE: a request (memRead or memWrite) latches op, byteAccess, address and dataWrite. Next state is WAIT if WAIT_STATES > 0, else DONE. With no request, the FSM stays in IDLE.
  - WAIT: a 4-bit counter loads WAIT_STATES-1 on entry and decrements each cycle. The FSM moves to DONE when the counter reaches 0.
  - DONE: a write commits to storage on the exit edge. A read's data is registered into dataRead on the entry edge, so it is valid during DONE. memValid is 1 for exactly this cycle. Next state is always IDLE.
- Requests are evaluated only in IDLE. Inputs present during DONE belong to the same request, because the pipeline is still held, and are ignored. The next request is accepted in the following IDLE cycle.
- memStall is combinational: 1 when (state==IDLE and request present) or state==WAIT; 0 in DONE and in idle IDLE. It is forced to 0 while reset_n is low.

## Timing
- Reset (reset_n low at an edge):
  - FSM goes to IDLE and the counter to 0.
  - dataRead=16'h0000, memValid=0, addrError=0.
  - All storage bytes are cleared to 8'h00.
- Reset mid-access (in WAIT or DONE) aborts the access. A pending write is discarded and no memValid is produced.
- Latency: request first seen in IDLE at cycle T. WAIT spans T+1 to T+WAIT_STATES. DONE is at T+WAIT_STATES+1. memStall is high for cycles T to T+WAIT_STATES, which is WAIT_STATES+1 cycles.
- Back-to-back accesses: the earliest next acceptance is cycle T+WAIT_STATES+2. Throughput is one access per WAIT_STATES+2 cycles.
- Read-after-write to the same address, in consecutive accesses, returns the new data.

## Configuration
- DMEM_ALIGN_CHECK_EN defined:
  - A word access with address[0]=1 is misaligned: no storage change, dataRead=16'h0000, and addrError=1 during DONE.
  - Timing is unchanged.
- DMEM_ALIGN_CHECK_EN undefined:
  - address[0] is forced to 0 for word accesses.
  - addrError is tied to 0.

## Test plan
- Reset then read at 0x0010 (word, WAIT_STATES=2) -> memStall high 3 cycles, DONE: memValid=1, dataRead=16'h0000.
- Word write 16'hBEEF at 0x0020, then word read 0x0020 -> dataRead=16'hBEEF; byte read 0x0021 -> 16'h00EF; byte read 0x0020 -> 16'h00BE.
- Byte write 8'h5A at 0x0031 over word 16'h1234 at 0x0030 -> word read 0x0030 returns 16'h125A.
- Word write 16'hCAFE at 0x0202 with DEPTH_BYTES=512 -> word read 0x0002 returns 16'hCAFE (wrap).
- Word read at 0x0005:
  - With DMEM_ALIGN_CHECK_EN: addrError=1 and memValid=1 in DONE, dataRead=16'h0000.
  - Without DMEM_ALIGN_CHECK_EN: returns the word at 0x0004.
- Word write 16'hFFFF at 0x0040 with reset_n pulsed low in the WAIT cycle -> no memValid, memStall=0; a later read of 0x0040 returns 16'h0000.

Source files
------------

// File: rtl/data_mem_responder.sv
// Data memory responder for the M stage: byte-organised storage with a
// configurable number of wait states. It holds the pipeline through memStall
// and pulses memValid when an access completes.
// Optional feature: define DMEM_ALIGN_CHECK_EN to flag misaligned word accesses
// on addrError. Without it, address[0] is ignored for word accesses.
module data_mem_responder #(
  parameter int unsigned DEPTH_BYTES = 512,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic        byteAccess,
  input  logic [15:0] address,
  input  logic [15:0] dataWrite,
  output logic [15:0] dataRead,
  output logic        memValid,
  output logic        memStall,
  output logic        addrError
);

  localparam int unsigned AW = $clog2(DEPTH_BYTES);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            wr_q;
  logic            byte_q;
  logic [AW-1:0]   addr_q;
  logic [15:0]     wdata_q;
  logic [15:0]     data_read_q;
  logic [7:0]      mem_q [DEPTH_BYTES];

  logic            req;
  logic            accept;
  logic            eff_wr;
  logic            eff_byte;
  logic [AW-1:0]   eff_addr;
  logic [AW-1:0]   idx_even;
  logic [AW-1:0]   idx_odd;
  logic            eff_misalign;
  logic [15:0]     rd_word;
  logic            load_read;
  logic            commit;

  assign req    = memRead | memWrite;
  assign accept = (state_q == StIdle) && req;

  // The live inputs describe the access on the acceptance edge; the latched
  // copy describes it afterwards. With zero wait states both edges coincide.
  assign eff_wr   = accept ? memWrite : wr_q;
  assign eff_byte = accept ? byteAccess : byte_q;
  assign eff_addr = accept ? address[AW-1:0] : addr_q;

  // Big-endian word: even byte is the high half.
  assign idx_even = {eff_addr[AW-1:1], 1'b0};
  assign idx_odd  = {eff_addr[AW-1:1], 1'b1};

`ifdef DMEM_ALIGN_CHECK_EN
  assign eff_misalign = !eff_byte && eff_addr[0];
`else
  assign eff_misalign = 1'b0;
`endif

  // Read data mux, zero-extending byte loads
  always_comb begin
    rd_word = 16'h0000;
    if (eff_misalign) begin
      rd_word = 16'h0000;
    end else if (eff_byte) begin
      rd_word = {8'h00, mem_q[eff_addr]};
    end else begin
      rd_word = {mem_q[idx_even], mem_q[idx_odd]};
    end
  end

  // Next-state and wait counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (WAIT_STATES > 0) begin
            state_d = StWait;
            cnt_d   = 4'(WAIT_STATES - 1);
          end else begin
            state_d = StDone;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 4'd0;
      end
    endcase
  end

  assign load_read = (state_d == StDone) && (state_q != StDone) && !eff_wr;
  assign commit    = (state_q == StDone) && wr_q && !eff_misalign;

  // FSM state, counter and request latch
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      byte_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        wr_q    <= memWrite;
        byte_q  <= byteAccess;
        addr_q  <= address[AW-1:0];
        wdata_q <= dataWrite;
      end
    end
  end

  // Storage: cleared on reset, written on the exit edge of DONE
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH_BYTES); i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (commit) begin
      if (byte_q) begin
        mem_q[eff_addr] <= wdata_q[7:0];
      end else begin
        mem_q[idx_even] <= wdata_q[15:8];
        mem_q[idx_odd]  <= wdata_q[7:0];
      end
    end
  end

  // Load data captured on the entry edge of DONE and held until the next read
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_read_q <= 16'h0000;
    end else if (load_read) begin
      data_read_q <= rd_word;
    end
  end

  assign dataRead  = data_read_q;
  assign memValid  = (state_q == StDone);
  assign addrError = (state_q == StDone) && eff_misalign;
  assign memStall  = reset_n && (accept || (state_q == StWait));

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder (DEPTH_BYTES=512,
// WAIT_STATES=2).
module tb_data_mem_responder;

  logic        clk;
  logic        reset_n;
  logic        memRead;
  logic        memWrite;
  logic        byteAccess;
  logic [15:0] address;
  logic [15:0] dataWrite;
  logic [15:0] dataRead;
  logic        memValid;
  logic        memStall;
  logic        addrError;

  int errors = 0;
  int checks = 0;

  data_mem_responder #(
    .DEPTH_BYTES(512),
    .WAIT_STATES(2)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .memRead   (memRead),
    .memWrite  (memWrite),
    .byteAccess(byteAccess),
    .address   (address),
    .dataWrite (dataWrite),
    .dataRead  (dataRead),
    .memValid  (memValid),
    .memStall  (memStall),
    .addrError (addrError)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one request at a falling edge and holds it until completion.
  // lat is the number of falling edges from request to memValid (-1 on timeout).
  task automatic access(input logic w, input logic r, input logic b, input logic [15:0] a,
                        input logic [15:0] d, output int stall_n, output int lat,
                        output logic [15:0] rd, output logic ae, output logic done_stall);
    @(negedge clk);
    memWrite   = w;
    memRead    = r;
    byteAccess = b;
    address    = a;
    dataWrite  = d;
    stall_n    = 0;
    lat        = -1;
    rd         = 16'hxxxx;
    ae         = 1'bx;
    done_stall = 1'bx;
    #1;
    if (memStall) stall_n++;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (memValid) begin
        lat        = i;
        rd         = dataRead;
        ae         = addrError;
        done_stall = memStall;
        break;
      end
      if (memStall) stall_n++;
    end
    memRead  = 1'b0;
    memWrite = 1'b0;
  endtask

  task automatic test_reset();
    memRead    = 1'b1;
    memWrite   = 1'b0;
    byteAccess = 1'b0;
    address    = 16'h0010;
    dataWrite  = 16'h0000;
    reset_n    = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (memStall !== 1'b0) begin
      errors++; $display("FAIL reset_stall got=%b exp=0", memStall);
    end
    checks++;
    if (memValid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got=%b exp=0", memValid);
    end
    checks++;
    if (dataRead !== 16'h0000) begin
      errors++; $display("FAIL reset_data got=%h exp=0000", dataRead);
    end
    checks++;
    if (addrError !== 1'b0) begin
      errors++; $display("FAIL reset_aerr got=%b exp=0", addrError);
    end
    memRead = 1'b0;
    reset_n = 1'b1;
  endtask

  task automatic test_first_read();
    int sn, lt; logic [15:0] rd; logic ae, ds;
    access(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, sn, lt, rd, ae, ds);
    checks++;
    if (sn !== 3) begin errors++; $display("FAIL first_stall_cycles got=%0d exp=3", sn); end
    checks++;
    if (lt !== 3) begin errors++; $display("FAIL first_latency got=%0d exp=3", lt); end
    checks++;
    if (rd !== 16'h0000) begin errors++; $display("FAIL first_data got=%h exp=0000", rd); end
    checks++;
    if (ds !== 1'b0) begin errors++; $display("FAIL first_done_stall got=%b exp=0", ds); end
    checks++;
    if (ae !== 1'b0) begin errors++; $display("FAIL first_aerr got=%b exp=0", ae); end
  endtask

  task automatic test_word_byte();
    int sn, lt; logic [15:0] rd; logic ae, ds;
    access(1'b1, 1'b0, 1'b0, 16'h0020, 16'hBEEF, sn, lt, rd, ae, ds);
    checks++;
    if (lt !== 3) begin errors++; $display("FAIL write_latency got=%0d exp=3", lt); end
    // A write leaves the previous load data in place
    checks++;
    if (rd !== 16'h0000) begin errors++; $display("FAIL write_holds_data got=%h exp=0000", rd); end
    access(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000, sn, lt, rd, ae, ds);
    checks++;
    if (rd !== 16'hBEEF) begin errors++; $display("FAIL word_read got=%h exp=BEEF", rd); end
    access(1'b0, 1'b1, 1'b1, 16'h0021, 16'h0000, sn, lt, rd, ae, ds);
    checks++;
    if (rd !== 16'h00EF) begin errors++; $display("FAIL byte_read_21 got=%h exp=00EF", rd); end
    access(1'b0, 1'b1, 1'b1, 16'h0020, 16'h0000, sn, lt, rd, ae, ds);
    checks++;
    if (rd !== 16'h00BE) begin errors++; $display("FAIL byte_read_20 got=%h exp=00BE", rd); end
    // Load data stays put while idle
    repeat (3) @(negedge clk);
    checks++;
    if (dataRead !== 16'h00BE) begin
      errors++; $display("FAIL data_hold got=%h exp=00BE", dataRead);
    end
  endtask

  task automatic test_byte_write();
    int sn, lt; logic [15:0] rd; logic ae, ds;
    access(1'b1, 1'b0, 1'b0, 16'h0030, 16'h1234, sn, lt, rd, ae, ds);
    access(1'b1, 1'b0, 1'b1, 16'h0031, 16'hAA5A, sn, lt, rd, ae, ds);
    access(1'b0, 1'b1, 1'b0, 16'h0030, 16'h0000, sn, lt, rd, ae, ds);
    checks++;
    if (rd !== 16'h125A) begin errors++; $display("FAIL byte_merge got=%h exp=125A", rd); end
  endtask

  task automatic test_both_is_write();
    int sn, lt; logic [15:0] rd; logic ae, ds;
    // Read and write together: treated as a write, load data untouched
    access(1'b1, 1'b1, 1'b0, 16'h0050, 16'h4321, sn, lt, rd, ae, ds);
    checks++;
    if (rd !== 16'h125A) begin errors++; $display("FAIL both_holds_data got=%h exp=125A", rd); end
    access(1'b0, 1'b1, 1'b0, 16'h0050, 16'h0000, sn, lt, rd, ae, ds);
    checks++;
    if (rd !== 16'h4321) begin errors++; $display("FAIL both_wrote got=%h exp=4321", rd); end
  endtask

  task automatic test_wrap();
    int sn, lt; logic [15:0] rd; logic ae, ds;
    access(1'b1, 1'b0, 1'b0, 16'h0202, 16'hCAFE, sn, lt, rd, ae, ds);
    access(1'b0, 1'b1, 1'b0, 16'h0002, 16'h0000, sn, lt, rd, ae, ds);
    checks++;
    if (rd !== 16'hCAFE) begin errors++; $display("FAIL wrap got=%h exp=CAFE", rd); end
  endtask

  task automatic test_misalign();
    int sn, lt; logic [15:0] rd; logic ae, ds;
    access(1'b1, 1'b0, 1'b0, 16'h0004, 16'h7788, sn, lt, rd, ae, ds);
    access(1'b0, 1'b1, 1'b0, 16'h0005, 16'h0000, sn, lt, rd, ae, ds);
    checks++;
    if (lt !== 3) begin errors++; $display("FAIL misalign_latency got=%0d exp=3", lt); end
`ifdef DMEM_ALIGN_CHECK_EN
    checks++;
    if (rd !== 16'h0000) begin errors++; $display("FAIL misalign_data got=%h exp=0000", rd); end
    checks++;
    if (ae !== 1'b1) begin errors++; $display("FAIL misalign_aerr got=%b exp=1", ae); end
`else
    checks++;
    if (rd !== 16'h7788) begin errors++; $display("FAIL misalign_data got=%h exp=7788", rd); end
    checks++;
    if (ae !== 1'b0) begin errors++; $display("FAIL misalign_aerr got=%b exp=0", ae); end
    // Misaligned word write lands on the even address below
    access(1'b1, 1'b0, 1'b0, 16'h0007, 16'h99AB, sn, lt, rd, ae, ds);
    access(1'b0, 1'b1, 1'b1, 16'h0006, 16'h0000, sn, lt, rd, ae, ds);
    checks++;
    if (rd !== 16'h0099) begin errors++; $display("FAIL misalign_write got=%h exp=0099", rd); end
`endif
  endtask

  task automatic test_back_to_back();
    int first, gap;
    first = -1;
    gap   = -1;
    @(negedge clk);
    memRead    = 1'b1;
    memWrite   = 1'b0;
    byteAccess = 1'b0;
    address    = 16'h0020;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (memValid) begin first = i; break; end
    end
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (memValid) begin gap = i; break; end
    end
    memRead = 1'b0;
    checks++;
    if (first !== 3) begin errors++; $display("FAIL b2b_first got=%0d exp=3", first); end
    checks++;
    if (gap !== 4) begin errors++; $display("FAIL b2b_period got=%0d exp=4", gap); end
  endtask

  task automatic test_reset_mid();
    int sn, lt; logic [15:0] rd; logic ae, ds;
    int valid_seen, stall_seen;
    @(negedge clk);
    memWrite   = 1'b1;
    memRead    = 1'b0;
    byteAccess = 1'b0;
    address    = 16'h0040;
    dataWrite  = 16'hFFFF;
    @(negedge clk);
    checks++;
    if (memStall !== 1'b1) begin errors++; $display("FAIL mid_wait_stall got=%b exp=1", memStall); end
    reset_n  = 1'b0;
    memWrite = 1'b0;
    #1;
    checks++;
    if (memStall !== 1'b0) begin errors++; $display("FAIL mid_forced_stall got=%b exp=0", memStall); end
    @(negedge clk);
    reset_n    = 1'b1;
    valid_seen = 0;
    stall_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (memValid) valid_seen++;
      if (memStall) stall_seen++;
    end
    checks++;
    if (valid_seen !== 0) begin errors++; $display("FAIL mid_no_valid got=%0d exp=0", valid_seen); end
    checks++;
    if (stall_seen !== 0) begin errors++; $display("FAIL mid_no_stall got=%0d exp=0", stall_seen); end
    access(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0000, sn, lt, rd, ae, ds);
    checks++;
    if (rd !== 16'h0000) begin errors++; $display("FAIL mid_discarded got=%h exp=0000", rd); end
    access(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000, sn, lt, rd, ae, ds);
    checks++;
    if (rd !== 16'h0000) begin errors++; $display("FAIL mid_cleared got=%h exp=0000", rd); end
  endtask

  initial begin
    test_reset();
    test_first_read();
    test_word_byte();
    test_byte_write();
    test_both_is_write();
    test_wrap();
    test_misalign();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
